// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port (I) and the load/store port (D).
// One transaction at a time; D wins ties unless I has been starved STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_wsize,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [1:0]    m_wsize,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT3  = 3'(MEM_LAT);
    localparam logic [2:0] SMAX3 = 3'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic       owner_d;
    logic       we_r;
    logic [1:0] wsize_r;
    logic [2:0] wait_cnt;
    logic [2:0] starve_cnt;
    logic       grant;
    logic       pick_d;
    logic       capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick_d    = 1'b0;
        capture   = 1'b0;
        busy      = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_wsize   = 2'b00;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    // I is forced only when both request and D has used up its run of wins.
                    pick_d    = d_req && !(i_req && (starve_cnt == SMAX3));
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                grant_d   = owner_d;
                m_en      = 1'b1;
                m_we      = we_r;
                m_wsize   = we_r ? wsize_r : 2'b00;
                state_nxt = we_r ? RESP : WAIT;
            end
            WAIT: begin
                busy    = 1'b1;
                grant_d = owner_d;
                if (wait_cnt == 3'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                grant_d   = owner_d;
                i_ack     = !owner_d;
                d_ack     = owner_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d    <= 1'b0;
            we_r       <= 1'b0;
            wsize_r    <= 2'b00;
            m_addr     <= '0;
            m_wdata    <= '0;
            wait_cnt   <= 3'd0;
            starve_cnt <= 3'd0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant) begin
                owner_d <= pick_d;
                we_r    <= pick_d && d_we;
                wsize_r <= pick_d ? d_wsize : 2'b00;
                m_addr  <= pick_d ? d_addr : i_addr;
                m_wdata <= pick_d ? d_wdata : '0;
                if (!pick_d) begin
                    starve_cnt <= 3'd0;
                end else if (i_req && (starve_cnt < SMAX3)) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= LAT3;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            // Read data lands in the last WAIT cycle; only the owner's register is written.
            if (capture) begin
                if (owner_d) begin
                    d_rdata <= m_rdata;
                end else begin
                    i_rdata <= m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1/STARVE_MAX=3 and MEM_LAT=4/STARVE_MAX=2)
// checked every cycle against a transaction-age model, plus directed literal scenarios.
module tb_mem_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;
    localparam int SM0  = 3;
    localparam int SM1  = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [1:0]          i_req, i_ack, d_req, d_we, d_ack, m_en, m_we, busy, grant_d;
    logic [1:0][AW-1:0]  i_addr, d_addr, m_addr;
    logic [1:0][DW-1:0]  i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
    logic [1:0][1:0]     d_wsize, m_wsize;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT0), .STARVE_MAX(SM0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_wsize(d_wsize[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_wsize(m_wsize[0]), .m_addr(m_addr[0]),
        .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]), .busy(busy[0]), .grant_d(grant_d[0])
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT1), .STARVE_MAX(SM1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_wsize(d_wsize[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_wsize(m_wsize[1]), .m_addr(m_addr[1]),
        .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]), .busy(busy[1]), .grant_d(grant_d[1])
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    logic [0:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // md_age = position of the current transaction: -1 idle, 1 = m_en cycle, total = ack cycle.
    int             md_age[2];
    bit             md_own_d[2];
    bit             md_store[2];
    logic [AW-1:0]  md_addr[2];
    logic [DW-1:0]  md_wdata[2];
    logic [1:0]     md_wsize[2];
    logic [DW-1:0]  md_ird[2];
    logic [DW-1:0]  md_drd[2];
    int             md_starve[2];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int smax_of(input int k);
        return (k == 0) ? SM0 : SM1;
    endfunction

    function automatic int total_of(input int k);
        return md_store[k] ? 2 : 2 + lat_of(k);
    endfunction

    function automatic bit d_wins(input int k);
        return d_req[k] && !(i_req[k] && (md_starve[k] == smax_of(k)));
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                md_age[k]    <= -1;
                md_own_d[k]  <= 1'b0;
                md_store[k]  <= 1'b0;
                md_addr[k]   <= '0;
                md_wdata[k]  <= '0;
                md_wsize[k]  <= '0;
                md_ird[k]    <= '0;
                md_drd[k]    <= '0;
                md_starve[k] <= 0;
            end else if (md_age[k] < 0) begin
                if (i_req[k] || d_req[k]) begin
                    md_age[k]   <= 1;
                    md_own_d[k] <= d_wins(k);
                    md_store[k] <= d_wins(k) && d_we[k];
                    md_addr[k]  <= d_wins(k) ? d_addr[k] : i_addr[k];
                    md_wdata[k] <= d_wdata[k];
                    md_wsize[k] <= d_wsize[k];
                    if (!d_wins(k)) begin
                        md_starve[k] <= 0;
                    end else if (i_req[k] && md_starve[k] < smax_of(k)) begin
                        md_starve[k] <= md_starve[k] + 1;
                    end
                end
            end else begin
                if (!md_store[k] && md_age[k] == 1 + lat_of(k)) begin
                    if (md_own_d[k]) md_drd[k] <= m_rdata[k];
                    else             md_ird[k] <= m_rdata[k];
                end
                md_age[k] <= (md_age[k] == total_of(k)) ? -1 : md_age[k] + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.busy", k), busy[k], md_age[k] >= 1);
                chk($sformatf("u%0d.m_en", k), m_en[k], md_age[k] == 1);
                chk($sformatf("u%0d.m_we", k), m_we[k], md_age[k] == 1 && md_store[k]);
                chk($sformatf("u%0d.m_wsize", k), m_wsize[k],
                    (md_age[k] == 1 && md_store[k]) ? md_wsize[k] : 2'b00);
                chk($sformatf("u%0d.grant_d", k), grant_d[k], md_age[k] >= 1 && md_own_d[k]);
                chk($sformatf("u%0d.i_ack", k), i_ack[k],
                    md_age[k] >= 1 && md_age[k] == total_of(k) && !md_own_d[k]);
                chk($sformatf("u%0d.d_ack", k), d_ack[k],
                    md_age[k] >= 1 && md_age[k] == total_of(k) && md_own_d[k]);
                chk($sformatf("u%0d.i_rdata", k), i_rdata[k], md_ird[k]);
                chk($sformatf("u%0d.d_rdata", k), d_rdata[k], md_drd[k]);
                if (md_age[k] >= 1) begin
                    chk($sformatf("u%0d.m_addr", k), m_addr[k], md_addr[k]);
                end
                if (md_age[k] == 1 && md_store[k]) begin
                    chk($sformatf("u%0d.m_wdata", k), m_wdata[k], md_wdata[k]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_rand(input int k);
        m_rdata[k] = $urandom;
        if (i_req[k]) begin
            if (i_ack[k]) begin
                if ($urandom_range(0, 3) != 0) i_addr[k] = AW'($urandom);
                else                           i_req[k]  = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            i_req[k]  = 1'b1;
            i_addr[k] = AW'($urandom);
        end
        if (d_req[k]) begin
            if (d_ack[k]) begin
                if ($urandom_range(0, 3) != 0) begin
                    d_we[k]    = 1'($urandom_range(0, 1));
                    d_wsize[k] = 2'($urandom_range(1, 3));
                    d_addr[k]  = AW'($urandom);
                    d_wdata[k] = $urandom;
                end else begin
                    d_req[k] = 1'b0;
                end
            end
        end else if ($urandom_range(0, 2) == 0) begin
            d_req[k]   = 1'b1;
            d_we[k]    = 1'($urandom_range(0, 1));
            d_wsize[k] = 2'($urandom_range(1, 3));
            d_addr[k]  = AW'($urandom);
            d_wdata[k] = $urandom;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_gr;
        int n_en;
        int c;
        logic got;
        logic expd;

        rst     = 1'b0;
        i_req   = '0;
        i_addr  = '0;
        d_req   = '0;
        d_we    = '0;
        d_wsize = '0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        repeat (3) tick();
        rst    = 1'b1;
        chk_en = 1'b1;

        // Reset state and an idle stretch
        for (int k = 0; k < 2; k++) begin
            chk("rst.i_rdata", i_rdata[k], 0);
            chk("rst.d_rdata", d_rdata[k], 0);
            chk("rst.m_wdata", m_wdata[k], 0);
        end
        repeat (20) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                chk("idle.m_en", m_en[k], 0);
                chk("idle.busy", busy[k], 0);
                chk("idle.i_ack", i_ack[k], 0);
                chk("idle.d_ack", d_ack[k], 0);
                chk("idle.m_addr", m_addr[k], 0);
            end
        end

        // Fetch with MEM_LAT=1
        m_rdata[0] = 32'h2002000A;
        i_req[0]   = 1'b1;
        i_addr[0]  = 10'h004;
        tick();
        chk("t1.c1.m_en", m_en[0], 1);
        chk("t1.c1.m_addr", m_addr[0], 10'h004);
        chk("t1.c1.m_we", m_we[0], 0);
        tick();
        chk("t1.c2.m_en", m_en[0], 0);
        chk("t1.c2.i_ack", i_ack[0], 0);
        tick();
        chk("t1.c3.i_ack", i_ack[0], 1);
        chk("t1.c3.i_rdata", i_rdata[0], 32'h2002000A);
        i_req[0] = 1'b0;
        tick();

        // Word store
        d_req[0]   = 1'b1;
        d_we[0]    = 1'b1;
        d_wsize[0] = 2'b11;
        d_addr[0]  = 10'h010;
        d_wdata[0] = 32'hDEADBEEF;
        tick();
        chk("t2.c1.m_en", m_en[0], 1);
        chk("t2.c1.m_we", m_we[0], 1);
        chk("t2.c1.m_wsize", m_wsize[0], 2'b11);
        chk("t2.c1.m_wdata", m_wdata[0], 32'hDEADBEEF);
        chk("t2.c1.m_addr", m_addr[0], 10'h010);
        chk("t2.c1.i_ack", i_ack[0], 0);
        tick();
        chk("t2.c2.d_ack", d_ack[0], 1);
        chk("t2.c2.i_ack", i_ack[0], 0);
        chk("t2.c2.d_rdata", d_rdata[0], 0);
        d_req[0] = 1'b0;
        d_we[0]  = 1'b0;
        tick();

        // Both ports held high: D,D,D,I,D,D,D,I
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        i_req[0]  = 1'b1;
        i_addr[0] = 10'h100;
        d_req[0]  = 1'b1;
        d_addr[0] = 10'h200;
        n_gr = 0;
        c    = 0;
        while (n_gr < 8 && c < 200) begin
            tick();
            c++;
            if (m_en[0]) begin
                got  = grant_d[0];
                expd = exp_q.pop_front();
                chk($sformatf("t3.grant%0d", n_gr), got, expd);
                if (!expd) chk("t3.starve_after_i", u_dut0.starve_cnt, 0);
                n_gr++;
            end
        end
        chk("t3.grant_count", n_gr, 8);
        c = 0;
        while (!i_ack[0] && c < 20) begin
            tick();
            c++;
        end
        chk("t3.final_i_ack", i_ack[0], 1);
        i_req[0] = 1'b0;
        d_req[0] = 1'b0;
        tick();

        // Load with MEM_LAT=4 at the top address
        m_rdata[1] = '0;
        d_req[1]   = 1'b1;
        d_we[1]    = 1'b0;
        d_addr[1]  = 10'h3FC;
        n_en = 0;
        for (int cc = 1; cc <= 6; cc++) begin
            tick();
            m_rdata[1] = 32'hA5A50000 | 32'(cc);
            if (m_en[1]) n_en++;
            if (cc == 1) chk("t4.m_addr", m_addr[1], 10'h3FC);
            chk($sformatf("t4.c%0d.busy", cc), busy[1], 1);
            chk($sformatf("t4.c%0d.d_ack", cc), d_ack[1], cc == 6);
            chk($sformatf("t4.c%0d.i_ack", cc), i_ack[1], 0);
            if (cc == 6) begin
                chk("t4.d_rdata", d_rdata[1], 32'hA5A50005);
                d_req[1] = 1'b0;
            end
        end
        tick();
        chk("t4.busy_after", busy[1], 0);
        chk("t4.m_en_pulses", n_en, 1);

        // Reset in the second WAIT cycle of a fetch
        i_req[1]  = 1'b1;
        i_addr[1] = 10'h155;
        repeat (3) tick();
        chk("t5.busy_before", busy[1], 1);
        rst = 1'b0;
        #1;
        chk("t5.m_en", m_en[1], 0);
        chk("t5.i_ack", i_ack[1], 0);
        chk("t5.busy", busy[1], 0);
        chk("t5.m_addr", m_addr[1], 0);
        chk("t5.i_rdata", i_rdata[1], 0);
        i_req[1] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) begin
            tick();
            chk("t5.no_ack", i_ack[1], 0);
        end
        chk("t5.starve", u_dut1.starve_cnt, 0);
        i_req[1]  = 1'b1;
        i_addr[1] = 10'h0AA;
        tick();
        chk("t5.new.m_en", m_en[1], 1);
        chk("t5.new.m_addr", m_addr[1], 10'h0AA);
        c = 0;
        while (!i_ack[1] && c < 20) begin
            tick();
            c++;
        end
        chk("t5.new.i_ack", i_ack[1], 1);
        i_req[1] = 1'b0;
        tick();

        // Randomised traffic on both instances
        for (int r = 0; r < 4000; r++) begin
            tick();
            drive_rand(0);
            drive_rand(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
